// File: rtl/array_ctrl_pkg.sv
// Shared types and helpers for the systolic-array sequencer.
//   ctrl_state_t : sequencer FSM state encoding
//   skew_len()   : FLUSH/DRAIN length, i.e. cycles for a skewed wavefront to cross the array
package array_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWload,
        StCompute,
        StFlush,
        StDrain,
        StDone
    } ctrl_state_t;

    function automatic int unsigned skew_len(int unsigned height, int unsigned width);
        return height + width - 1;
    endfunction

endpackage

// File: rtl/array_ctrl_skew_line.sv
// skew_line: 1-bit delay line exposing every tap.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of all stages
//   din        : base signal
//   taps[k]    : din delayed k cycles (taps[0] is din itself)
module skew_line #(
    parameter int unsigned LEN = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           din,
    output logic [LEN-1:0] taps
);

    generate
        if (LEN > 1) begin : g_line
            logic [LEN-1:1] stage_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_q <= '0;
                end else if (clr) begin
                    stage_q <= '0;
                end else begin
                    stage_q[1] <= din;
                    for (int i = 2; i < LEN; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign taps = {stage_q, din};
        end else begin : g_wire
            assign taps = din;
        end
    endgenerate

endmodule

// File: rtl/array_ctrl.sv
// array_ctrl: one-tile sequencer for a HEIGHT x WIDTH unary-rate systolic array.
//   start / abort                : begin tile (IDLE only) / synchronous return to IDLE
//   cfg_mac_cycles, cfg_num_vec  : M (0 treated as 1) and N, latched on accepted start
//   busy, done                   : not-IDLE flag, one-cycle end-of-tile pulse
//   wght_req, ifm_req            : buffer pops (one per WLOAD cycle / one per vector)
//   en_i, clr_i, mac_done        : row controls, bit h delayed h cycles
//   en_w, clr_w, en_o, clr_o     : column controls, bit w delayed w cycles
//   ofm_valid                    : en_o registered one cycle
module array_ctrl
    import array_ctrl_pkg::*;
#(
    parameter int unsigned HEIGHT = 4,
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CWIDTH-1:0] cfg_mac_cycles,
    input  logic [CWIDTH-1:0] cfg_num_vec,
    output logic              busy,
    output logic              done,
    output logic              wght_req,
    output logic              ifm_req,
    output logic [HEIGHT-1:0] en_i,
    output logic [HEIGHT-1:0] clr_i,
    output logic [HEIGHT-1:0] mac_done,
    output logic [WIDTH-1:0]  en_w,
    output logic [WIDTH-1:0]  clr_w,
    output logic [WIDTH-1:0]  en_o,
    output logic [WIDTH-1:0]  clr_o,
    output logic [WIDTH-1:0]  ofm_valid
);

    localparam int unsigned SLEN = skew_len(HEIGHT, WIDTH);
    localparam logic [CWIDTH-1:0] H_LAST = CWIDTH'(HEIGHT - 1);
    localparam logic [CWIDTH-1:0] S_LAST = CWIDTH'(SLEN - 1);
    localparam logic [CWIDTH-1:0] ONE    = CWIDTH'(1);

    ctrl_state_t       state_q, state_d;
    logic [CWIDTH-1:0] cyc_q, cyc_d;
    logic [CWIDTH-1:0] vec_q, vec_d;
    logic [CWIDTH-1:0] m_last_q, m_last_d;
    logic [CWIDTH-1:0] num_vec_q, num_vec_d;
    logic [WIDTH-1:0]  ofm_valid_q;

    logic b_en_i, b_clr_i, b_mac_done;
    logic b_en_w, b_clr_w, b_en_o, b_clr_o;

    // cyc_q is shared: phase counter in WLOAD/FLUSH/DRAIN, bit counter within a vector in COMPUTE.
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        vec_d     = vec_q;
        m_last_d  = m_last_q;
        num_vec_d = num_vec_q;
        if (abort) begin
            state_d = StIdle;
            cyc_d   = '0;
            vec_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d   = StWload;
                        cyc_d     = '0;
                        vec_d     = '0;
                        m_last_d  = (cfg_mac_cycles == '0) ? '0 : cfg_mac_cycles - ONE;
                        num_vec_d = cfg_num_vec;
                    end
                end
                StWload: begin
                    if (cyc_q == H_LAST) begin
                        cyc_d   = '0;
                        state_d = (num_vec_q == '0) ? StFlush : StCompute;
                    end else begin
                        cyc_d = cyc_q + ONE;
                    end
                end
                StCompute: begin
                    if (cyc_q == m_last_q) begin
                        cyc_d = '0;
                        if (vec_q == num_vec_q - ONE) begin
                            vec_d   = '0;
                            state_d = StFlush;
                        end else begin
                            vec_d = vec_q + ONE;
                        end
                    end else begin
                        cyc_d = cyc_q + ONE;
                    end
                end
                StFlush: begin
                    if (cyc_q == S_LAST) begin
                        cyc_d   = '0;
                        state_d = StDrain;
                    end else begin
                        cyc_d = cyc_q + ONE;
                    end
                end
                StDrain: begin
                    if (cyc_q == S_LAST) begin
                        cyc_d   = '0;
                        state_d = StDone;
                    end else begin
                        cyc_d = cyc_q + ONE;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cyc_q       <= '0;
            vec_q       <= '0;
            m_last_q    <= '0;
            num_vec_q   <= '0;
            ofm_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            vec_q       <= vec_d;
            m_last_q    <= m_last_d;
            num_vec_q   <= num_vec_d;
            ofm_valid_q <= abort ? '0 : en_o;
        end
    end

    // Base (unskewed) controls, decoded straight from state and counters.
    always_comb begin
        b_en_w     = (state_q == StWload);
        b_clr_w    = b_en_w && (cyc_q == '0);
        b_en_i     = (state_q == StCompute);
        b_clr_i    = b_en_i && (cyc_q == '0);
        b_mac_done = b_en_i && (cyc_q == m_last_q);
        b_en_o     = (state_q == StDrain) && (cyc_q <= H_LAST);
        b_clr_o    = (state_q == StDrain) && (cyc_q == '0);
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign wght_req  = b_en_w;
    assign ifm_req   = b_clr_i;
    assign ofm_valid = ofm_valid_q;

    skew_line #(.LEN(HEIGHT)) u_skew_en_i (
        .clk(clk), .rst_n(rst_n), .clr(abort), .din(b_en_i), .taps(en_i)
    );
    skew_line #(.LEN(HEIGHT)) u_skew_clr_i (
        .clk(clk), .rst_n(rst_n), .clr(abort), .din(b_clr_i), .taps(clr_i)
    );
    skew_line #(.LEN(HEIGHT)) u_skew_mac_done (
        .clk(clk), .rst_n(rst_n), .clr(abort), .din(b_mac_done), .taps(mac_done)
    );
    skew_line #(.LEN(WIDTH)) u_skew_en_w (
        .clk(clk), .rst_n(rst_n), .clr(abort), .din(b_en_w), .taps(en_w)
    );
    skew_line #(.LEN(WIDTH)) u_skew_clr_w (
        .clk(clk), .rst_n(rst_n), .clr(abort), .din(b_clr_w), .taps(clr_w)
    );
    skew_line #(.LEN(WIDTH)) u_skew_en_o (
        .clk(clk), .rst_n(rst_n), .clr(abort), .din(b_en_o), .taps(en_o)
    );
    skew_line #(.LEN(WIDTH)) u_skew_clr_o (
        .clk(clk), .rst_n(rst_n), .clr(abort), .din(b_clr_o), .taps(clr_o)
    );

endmodule

// File: tb/tb_array_ctrl.sv
// Bench for array_ctrl: a 4x4 instance (a) and a 2x5 instance (b). Expected outputs come from
// closed-form tile timing; done cycles go through a scoreboard queue.
module tb_array_ctrl;

    localparam int NONE = -100000;
    localparam int BIG  = 1000000;

    // model signal kinds
    localparam int K_WREQ = 0;
    localparam int K_CLRW = 1;
    localparam int K_ENI  = 2;
    localparam int K_CLRI = 3;
    localparam int K_MACD = 4;
    localparam int K_ENO  = 5;
    localparam int K_CLRO = 6;
    localparam int K_BUSY = 7;
    localparam int K_DONE = 8;

    logic        clk;
    logic        rst_n;
    logic        start_a, start_b, abort;
    logic [15:0] cfg_mac_cycles, cfg_num_vec;

    logic       busy_a, done_a, wght_req_a, ifm_req_a;
    logic [3:0] en_i_a, clr_i_a, mac_done_a, en_w_a, clr_w_a, en_o_a, clr_o_a, ofm_valid_a;
    logic       busy_b, done_b, wght_req_b, ifm_req_b;
    logic [1:0] en_i_b, clr_i_b, mac_done_b;
    logic [4:0] en_w_b, clr_w_b, en_o_b, clr_o_b, ofm_valid_b;

    int n_tests = 0;
    int n_fail  = 0;
    int sb_q[$];

    // current tile scenario, read by the model
    int sel, cur_m, cur_n, cur_h, cur_w, st0, st1, kill;

    array_ctrl #(.HEIGHT(4), .WIDTH(4), .CWIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
        .cfg_mac_cycles(cfg_mac_cycles), .cfg_num_vec(cfg_num_vec),
        .busy(busy_a), .done(done_a), .wght_req(wght_req_a), .ifm_req(ifm_req_a),
        .en_i(en_i_a), .clr_i(clr_i_a), .mac_done(mac_done_a),
        .en_w(en_w_a), .clr_w(clr_w_a), .en_o(en_o_a), .clr_o(clr_o_a),
        .ofm_valid(ofm_valid_a)
    );

    array_ctrl #(.HEIGHT(2), .WIDTH(5), .CWIDTH(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
        .cfg_mac_cycles(cfg_mac_cycles), .cfg_num_vec(cfg_num_vec),
        .busy(busy_b), .done(done_b), .wght_req(wght_req_b), .ifm_req(ifm_req_b),
        .en_i(en_i_b), .clr_i(clr_i_b), .mac_done(mac_done_b),
        .en_w(en_w_b), .clr_w(clr_w_b), .en_o(en_o_b), .clr_o(clr_o_b),
        .ofm_valid(ofm_valid_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Base signal of one tile whose start was sampled at relative cycle 0.
    function automatic logic base_sig(int kind, int t);
        int me, cs, fs, s, ds;
        me = (cur_m == 0) ? 1 : cur_m;
        cs = cur_h + 1;
        fs = cs + cur_n * me;
        s  = cur_h + cur_w - 1;
        ds = fs + s;
        case (kind)
            K_WREQ:  return t >= 1 && t <= cur_h;
            K_CLRW:  return t == 1;
            K_ENI:   return t >= cs && t < fs;
            K_CLRI:  return t >= cs && t < fs && ((t - cs) % me) == 0;
            K_MACD:  return t >= cs && t < fs && ((t - cs) % me) == me - 1;
            K_ENO:   return t >= ds && t < ds + cur_h;
            K_CLRO:  return t == ds;
            K_BUSY:  return t >= 1 && t <= ds + s;
            K_DONE:  return t == ds + s;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic any_tile(int kind, int t);
        logic v;
        v = (st0 != NONE) && base_sig(kind, t - st0);
        if (st1 != NONE) v = v | base_sig(kind, t - st1);
        return v;
    endfunction

    function automatic logic [31:0] exp_vec(int kind, int t, int len);
        logic [31:0] v;
        v = '0;
        for (int j = 0; j < len; j++) v[j] = any_tile(kind, t - j);
        return v;
    endfunction

    function automatic int tile_lat(int m, int n, int h, int w);
        int me;
        me = (m == 0) ? 1 : m;
        return 1 + h + n * me + 2 * (h + w - 1);
    endfunction

    task automatic check(input string tag, input int t, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic compare_all(input int t);
        logic [31:0] e_busy, e_done, e_wreq, e_ifm, e_eni, e_clri, e_macd;
        logic [31:0] e_enw, e_clrw, e_eno, e_clro, e_ofm;
        e_busy = 32'(any_tile(K_BUSY, t));
        e_done = 32'(any_tile(K_DONE, t));
        e_wreq = 32'(any_tile(K_WREQ, t));
        e_ifm  = 32'(any_tile(K_CLRI, t));
        e_eni  = exp_vec(K_ENI, t, cur_h);
        e_clri = exp_vec(K_CLRI, t, cur_h);
        e_macd = exp_vec(K_MACD, t, cur_h);
        e_enw  = exp_vec(K_WREQ, t, cur_w);
        e_clrw = exp_vec(K_CLRW, t, cur_w);
        e_eno  = exp_vec(K_ENO, t, cur_w);
        e_clro = exp_vec(K_CLRO, t, cur_w);
        e_ofm  = exp_vec(K_ENO, t - 1, cur_w);
        if (t > kill) begin
            {e_busy, e_done, e_wreq, e_ifm, e_eni, e_clri} = '0;
            {e_macd, e_enw, e_clrw, e_eno, e_clro, e_ofm}  = '0;
        end
        if (sel == 0) begin
            check("busy", t, 32'(busy_a), e_busy);
            check("done", t, 32'(done_a), e_done);
            check("wght_req", t, 32'(wght_req_a), e_wreq);
            check("ifm_req", t, 32'(ifm_req_a), e_ifm);
            check("en_i", t, 32'(en_i_a), e_eni);
            check("clr_i", t, 32'(clr_i_a), e_clri);
            check("mac_done", t, 32'(mac_done_a), e_macd);
            check("en_w", t, 32'(en_w_a), e_enw);
            check("clr_w", t, 32'(clr_w_a), e_clrw);
            check("en_o", t, 32'(en_o_a), e_eno);
            check("clr_o", t, 32'(clr_o_a), e_clro);
            check("ofm_valid", t, 32'(ofm_valid_a), e_ofm);
        end else begin
            check("b_busy", t, 32'(busy_b), e_busy);
            check("b_done", t, 32'(done_b), e_done);
            check("b_wght_req", t, 32'(wght_req_b), e_wreq);
            check("b_ifm_req", t, 32'(ifm_req_b), e_ifm);
            check("b_en_i", t, 32'(en_i_b), e_eni);
            check("b_clr_i", t, 32'(clr_i_b), e_clri);
            check("b_mac_done", t, 32'(mac_done_b), e_macd);
            check("b_en_w", t, 32'(en_w_b), e_enw);
            check("b_clr_w", t, 32'(clr_w_b), e_clrw);
            check("b_en_o", t, 32'(en_o_b), e_eno);
            check("b_clr_o", t, 32'(clr_o_b), e_clro);
            check("b_ofm_valid", t, 32'(ofm_valid_b), e_ofm);
        end
        // scoreboard: every observed done must match the oldest pending expected cycle
        if ((sel == 0 && done_a) || (sel == 1 && done_b)) begin
            if (sb_q.size() == 0) check("sb_spurious_done", t, 32'd1, 32'd0);
            else check("sb_done_cycle", t, 32'(t), 32'(sb_q.pop_front()));
        end
    endtask

    // mode: 0 plain, 1 abort at kill_at, 2 reset at kill_at, 3 start held, 4 pulses while busy
    task automatic run_tile(input int which, input int m, input int n, input int mode,
                            input int kill_at);
        int lat, nc;
        logic st;
        sel   = which;
        cur_m = m;
        cur_n = n;
        cur_h = (which == 0) ? 4 : 2;
        cur_w = (which == 0) ? 4 : 5;
        lat   = tile_lat(m, n, cur_h, cur_w);
        st0   = 0;
        st1   = (mode == 3) ? lat + 1 : NONE;
        kill  = (mode == 1 || mode == 2) ? kill_at : BIG;
        nc    = (mode == 3) ? 2 * lat + 3 : lat + 3;
        if (mode == 1 || mode == 2) nc = kill_at + 5;
        cfg_mac_cycles = 16'(m);
        cfg_num_vec    = 16'(n);
        for (int t = 0; t < nc; t++) begin
            @(posedge clk);
            #1;
            st = (t == 0) || (mode == 3 && t <= lat + 1) ||
                 (mode == 4 && (t == 3 || t == 12 || t == lat));
            start_a = st && (which == 0);
            start_b = st && (which == 1);
            abort   = (mode == 1 && t == kill_at);
            if (mode == 2 && t == kill_at + 2) rst_n = 1'b1;
            if (kill == BIG && (t == 0 || (mode == 3 && t == lat + 1))) sb_q.push_back(t + lat);
            @(negedge clk);
            compare_all(t);
            if (mode == 2 && t == kill_at) begin
                #1;
                rst_n = 1'b0;
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
        abort   = 1'b0;
        check("sb_pending_left", nc, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        rst_n          = 1'b0;
        start_a        = 1'b0;
        start_b        = 1'b0;
        abort          = 1'b0;
        cfg_mac_cycles = '0;
        cfg_num_vec    = '0;
        sel   = 0;
        cur_m = 1;
        cur_n = 1;
        cur_h = 4;
        cur_w = 4;
        st0   = NONE;
        st1   = NONE;
        kill  = BIG;

        // reset state of both instances
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            sel = 0;
            compare_all(t);
            sel = 1;
            cur_h = 2;
            cur_w = 5;
            compare_all(t);
            cur_h = 4;
            cur_w = 4;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_tile(0, 3, 2, 0, 0);   // basic tile: done at 25
        run_tile(0, 0, 3, 0, 0);   // M=0 behaves as M=1
        run_tile(0, 1, 3, 0, 0);
        run_tile(0, 3, 0, 0, 0);   // N=0: done at 19
        run_tile(0, 5, 1, 0, 0);
        run_tile(0, 3, 2, 1, 6);   // abort in COMPUTE
        run_tile(0, 3, 2, 2, 6);   // reset in COMPUTE
        run_tile(0, 2, 1, 3, 0);   // start held across two tiles
        run_tile(0, 2, 2, 4, 0);   // start pulses while busy
        run_tile(1, 2, 2, 0, 0);   // non-square 2x5
        run_tile(1, 1, 3, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule
